// File: rtl/merge_tree_nx1_pkg.sv
// Shared types and elaboration helpers for the N-to-1 merge tree.
package merge_tree_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Number of write channels feeding the tree.
    function automatic int n_ch(input int grp_sz, input int n_grp);
        return grp_sz * n_grp;
    endfunction

    // Width of an index/tag able to address n items (at least one bit).
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next round-robin candidate after cur, wrapping n-1 -> 0.
    function automatic int rr_next(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/merge_tree_nx1_if.sv
// Bus bundle of the merge tree: channel write side, overflow control and read port.
//
// Handshake: a word is transferred out on a rising edge where valid=1 and ren=1;
// ren with valid=0 does nothing. Writes have no ready: wen while o_full=1 drops
// the word and raises the sticky ovf bit of that channel.
interface merge_tree_nx1_if #(
    parameter int N_CH   = 9,
    parameter int DATA_W = 8,
    parameter int SRC_W  = 4
);
    logic [N_CH-1:0]        wen;
    logic [N_CH*DATA_W-1:0] i_data;
    logic [N_CH-1:0]        o_full;
    logic [N_CH-1:0]        ovf;
    logic                   clr_ovf;
    logic                   i_freeze;
    logic                   ren;
    logic                   valid;
    logic [DATA_W-1:0]      o_data;
    logic [SRC_W-1:0]       o_src;

    modport master (
        output wen, i_data, clr_ovf, i_freeze, ren,
        input  o_full, ovf, valid, o_data, o_src
    );

    modport slave (
        input  wen, i_data, clr_ovf, i_freeze, ren,
        output o_full, ovf, valid, o_data, o_src
    );
endinterface

// File: rtl/merge_tree_nx1_node.sv
// One arbitration node: picks one of NIN valid inputs (round-robin or fixed
// priority) into a single data+tag register. Used for both leaves and root.
module merge_node
    import merge_tree_pkg::*;
#(
    parameter int        NIN      = 3,
    parameter int        DATA_W   = 8,
    parameter int        TAG_W    = 4,
    parameter arb_mode_e ARB_MODE = ARB_RR
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  freeze,
    input  logic                  ready,
    input  logic [NIN-1:0]        in_valid,
    input  logic [NIN*DATA_W-1:0] in_data,
    input  logic [NIN*TAG_W-1:0]  in_tag,
    output logic [NIN-1:0]        pop,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int IDX_W = tag_w(NIN);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt;
    logic             load;

    // Grant selection and load decision; the register refills when it is empty
    // or being drained downstream this cycle, unless the pipeline is frozen.
    always_comb begin
        int               idx;
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt   = '0;
        found = 1'b0;
        idx   = int'(rr_ptr);
        cand  = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int k = NIN - 1; k >= 0; k--) begin
                cand = IDX_W'(k);
                if (in_valid[cand]) gnt = cand;
            end
        end else begin
            for (int k = 0; k < NIN; k++) begin
                idx  = rr_next(idx, NIN);
                cand = IDX_W'(idx);
                if (!found && in_valid[cand]) begin
                    gnt   = cand;
                    found = 1'b1;
                end
            end
        end
        load = (!out_valid || ready) && !freeze && (|in_valid);
        pop  = load ? (NIN'(1) << gnt) : '0;
    end

    // Output register and round-robin pointer (pointer moves only on a grant).
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            rr_ptr    <= IDX_W'(NIN - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*DATA_W +: DATA_W];
            out_tag   <= in_tag[gnt*TAG_W +: TAG_W];
            rr_ptr    <= gnt;
        end else if (ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/merge_tree_nx1.sv
// N-to-1 merge tree: per-channel FIFOs, GRP_SZ-input leaf nodes, one root node
// whose register is the read port. Tags carry the global channel index upward.
module merge_tree_nx1
    import merge_tree_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GRP_SZ     = 3,
    parameter int N_GRP      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic             clk_i,
    input  logic             reset_n,
    merge_tree_nx1_if.slave  bus
);
    localparam int        N_CH  = n_ch(GRP_SZ, N_GRP);
    localparam int        SRC_W = tag_w(N_CH);
    localparam int        PTR_W = $clog2(FIFO_DEPTH);
    localparam arb_mode_e MODE  = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [N_CH-1:0]         fifo_ne;
    logic [N_CH-1:0]         fifo_pop;
    logic [N_CH-1:0]         fifo_full;
    logic [N_CH*DATA_W-1:0]  fifo_data;
    logic [N_CH*SRC_W-1:0]   ch_tag;
    logic [N_CH-1:0]         ovf_q;
    logic [N_GRP-1:0]        leaf_valid;
    logic [N_GRP-1:0]        leaf_pop;
    logic [N_GRP*DATA_W-1:0] leaf_data;
    logic [N_GRP*SRC_W-1:0]  leaf_tag;
    logic                    root_valid;
    logic [DATA_W-1:0]       root_data;
    logic [SRC_W-1:0]        root_tag;
    logic                    root_ready;

    for (genvar c = 0; c < N_CH; c++) begin : g_fifo
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wptr;
        logic [PTR_W-1:0]  rptr;
        logic [PTR_W:0]    count;
        logic              wr;
        logic              ovf_bit;

        // Fullness is judged on the registered count, so a pop never frees a slot for a same-cycle write.
        assign fifo_full[c] = (count == (PTR_W+1)'(FIFO_DEPTH));
        assign wr           = bus.wen[c] & ~fifo_full[c];
        assign fifo_ne[c]   = (count != '0);
        assign fifo_data[c*DATA_W +: DATA_W] = mem[rptr];
        assign ch_tag[c*SRC_W +: SRC_W]      = SRC_W'(c);
        assign ovf_q[c]     = ovf_bit;

        // Pointer and occupancy bookkeeping.
        always_ff @(posedge clk_i) begin
            if (!reset_n) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr)          wptr <= wptr + 1'b1;
                if (fifo_pop[c]) rptr <= rptr + 1'b1;
                case ({wr, fifo_pop[c]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end

        // Word storage; contents are don't-care while the count says empty.
        always_ff @(posedge clk_i) begin
            if (wr) mem[wptr] <= bus.i_data[c*DATA_W +: DATA_W];
        end

        // Sticky drop flag; a clear in the same cycle as a drop wins.
        always_ff @(posedge clk_i) begin
            if (!reset_n)                        ovf_bit <= 1'b0;
            else if (bus.clr_ovf)                ovf_bit <= 1'b0;
            else if (bus.wen[c] && fifo_full[c]) ovf_bit <= 1'b1;
        end
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_leaf
        merge_node #(
            .NIN      (GRP_SZ),
            .DATA_W   (DATA_W),
            .TAG_W    (SRC_W),
            .ARB_MODE (MODE)
        ) u_leaf (
            .clk_i     (clk_i),
            .reset_n   (reset_n),
            .freeze    (bus.i_freeze),
            .ready     (leaf_pop[g]),
            .in_valid  (fifo_ne[g*GRP_SZ +: GRP_SZ]),
            .in_data   (fifo_data[g*GRP_SZ*DATA_W +: GRP_SZ*DATA_W]),
            .in_tag    (ch_tag[g*GRP_SZ*SRC_W +: GRP_SZ*SRC_W]),
            .pop       (fifo_pop[g*GRP_SZ +: GRP_SZ]),
            .out_valid (leaf_valid[g]),
            .out_data  (leaf_data[g*DATA_W +: DATA_W]),
            .out_tag   (leaf_tag[g*SRC_W +: SRC_W])
        );
    end

    // The output register drains on ren even while frozen; only refills are held.
    assign root_ready = bus.ren & root_valid;

    merge_node #(
        .NIN      (N_GRP),
        .DATA_W   (DATA_W),
        .TAG_W    (SRC_W),
        .ARB_MODE (MODE)
    ) u_root (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .freeze    (bus.i_freeze),
        .ready     (root_ready),
        .in_valid  (leaf_valid),
        .in_data   (leaf_data),
        .in_tag    (leaf_tag),
        .pop       (leaf_pop),
        .out_valid (root_valid),
        .out_data  (root_data),
        .out_tag   (root_tag)
    );

    assign bus.valid  = root_valid;
    assign bus.o_data = root_data;
    assign bus.o_src  = root_tag;
    assign bus.o_full = fifo_full;
    assign bus.ovf    = ovf_q;

endmodule
